// File: rtl/input_buffer_vc.sv
// Per-port NoC input buffer: one FIFO per virtual channel, VC locked from head to tail flit.
// Optional registered per-VC occupancy output occ_o when IB_OCCUPANCY_EN is defined.
module input_buffer_vc #(
   parameter int FLIT_W = 37,
   parameter int N_VC   = 2,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              arst,
   input  logic [FLIT_W-1:0] flit_i,
   input  logic              flit_valid_i,
   output logic              flit_ready_o,
   output logic [FLIT_W-1:0] flit_req_o,
   output logic              flit_valid_o,
   input  logic              flit_ready_i,
   output logic [N_VC-1:0]   vc_full_o
`ifdef IB_OCCUPANCY_EN
   ,
   output logic [N_VC*($clog2(DEPTH)+1)-1:0] occ_o
`endif
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   logic [FLIT_W-1:0] r_mem  [N_VC][DEPTH];
   logic [AW:0]       r_wptr [N_VC];
   logic [AW:0]       r_rptr [N_VC];
   state_t            r_state, w_nstate;
   logic              r_lock_vc, w_nlock;
   logic              r_rr, w_nrr;

   logic [N_VC-1:0]   w_empty, w_full;
   logic              w_wvc, w_push;
   logic              w_sel, w_avail, w_discard, w_valid, w_fwd, w_pop;
   logic [FLIT_W-1:0] w_head;

   assign w_wvc        = flit_i[2];
   assign flit_ready_o = !w_full[w_wvc];
   assign w_push       = flit_valid_i && flit_ready_o;
   assign vc_full_o    = w_full;
   assign flit_valid_o = w_valid;
   assign flit_req_o   = w_valid ? w_head : '0;

   // Wrap bit distinguishes full from empty when the low pointer bits match.
   always_comb begin
      for (int v = 0; v < N_VC; v++) begin
         w_empty[v] = (r_wptr[v] == r_rptr[v]);
         w_full[v]  = (r_wptr[v][AW] != r_rptr[v][AW]) &&
                      (r_wptr[v][AW-1:0] == r_rptr[v][AW-1:0]);
      end
   end

   always_comb begin
      w_nstate  = r_state;
      w_nlock   = r_lock_vc;
      w_nrr     = r_rr;
      w_sel     = r_rr;
      w_avail   = 1'b0;
      w_discard = 1'b0;
      w_valid   = 1'b0;
      w_fwd     = 1'b0;
      w_pop     = 1'b0;
      if (r_state == S_LOCKED) begin
         w_sel   = r_lock_vc;
         w_avail = !w_empty[r_lock_vc];
      end else if (!w_empty[r_rr]) begin
         w_sel   = r_rr;
         w_avail = 1'b1;
      end else if (!w_empty[~r_rr]) begin
         w_sel   = ~r_rr;
         w_avail = 1'b1;
      end
      w_head = r_mem[w_sel][r_rptr[w_sel][AW-1:0]];
      // A body flit reaching the head while unlocked is orphaned; drop it silently.
      w_discard = (r_state == S_IDLE) && w_avail && !w_head[0];
      w_valid   = w_avail && !w_discard;
      w_fwd     = w_valid && flit_ready_i;
      w_pop     = w_fwd || w_discard;
      if (w_fwd) begin
         if (r_state == S_IDLE) begin
            w_nrr = ~w_sel;
            if (!w_head[1]) begin
               w_nstate = S_LOCKED;
               w_nlock  = w_sel;
            end
         end else if (w_head[1]) begin
            w_nstate = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         for (int v = 0; v < N_VC; v++) begin
            r_wptr[v] <= '0;
            r_rptr[v] <= '0;
         end
         r_state   <= S_IDLE;
         r_lock_vc <= 1'b0;
         r_rr      <= 1'b0;
      end else begin
         for (int v = 0; v < N_VC; v++) begin
            if (w_push && (w_wvc == 1'(v)))
               r_wptr[v] <= r_wptr[v] + (AW+1)'(1);
            if (w_pop && (w_sel == 1'(v)))
               r_rptr[v] <= r_rptr[v] + (AW+1)'(1);
         end
         r_state   <= w_nstate;
         r_lock_vc <= w_nlock;
         r_rr      <= w_nrr;
      end
   end

   // Storage carries no reset; validity is defined entirely by the pointers.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[w_wvc][r_wptr[w_wvc][AW-1:0]] <= flit_i;
   end

`ifdef IB_OCCUPANCY_EN
   logic [AW:0] r_occ [N_VC];

   always_ff @(posedge clk) begin
      if (arst) begin
         for (int v = 0; v < N_VC; v++)
            r_occ[v] <= '0;
      end else begin
         for (int v = 0; v < N_VC; v++) begin
            case ({w_push && (w_wvc == 1'(v)), w_pop && (w_sel == 1'(v))})
               2'b10:   r_occ[v] <= r_occ[v] + (AW+1)'(1);
               2'b01:   r_occ[v] <= r_occ[v] - (AW+1)'(1);
               default: r_occ[v] <= r_occ[v];
            endcase
         end
      end
   end

   always_comb begin
      occ_o = '0;
      for (int v = 0; v < N_VC; v++)
         occ_o[v*(AW+1) +: (AW+1)] = r_occ[v];
   end
`endif

endmodule
